// File: rtl/trinary_pkg.sv
// ---------------------------------------------------------------------------
// trinary_pkg
// Shared trinary definitions for the Curl front-end.
//   - tryte alphabet and value range constants
//   - trit2_t: 2-bit encoded balanced trit (00 = 0, 01 = +1, 11 = -1)
//   - HASH_LENGTH: trits absorbed per Curl block
//   - char_to_tryte_value: ASCII tryte character -> signed value plus valid
//   - loader_state_t: FSM states of the tryte loader
// ---------------------------------------------------------------------------
package trinary_pkg;

    localparam int NUMBER_OF_TRITS_IN_A_TRYTE = 3;
    localparam int MIN_TRYTE_VALUE            = -13;
    localparam int MAX_TRYTE_VALUE            = 13;
    localparam int HASH_LENGTH                = 243;

    // Alphabet size follows from the value range rather than being restated.
    localparam int TRYTE_ALPHABET_SIZE = MAX_TRYTE_VALUE - MIN_TRYTE_VALUE + 1;

    // Character at alphabet index i sits in byte (TRYTE_ALPHABET_SIZE-1-i),
    // since the first character of a string literal lands in the MSBs.
    localparam logic [8*TRYTE_ALPHABET_SIZE-1:0] TRYTE_STRING =
        "9ABCDEFGHIJKLMNOPQRSTUVWXYZ";

    typedef logic [1:0] trit2_t;

    localparam trit2_t TRIT2_ZERO = 2'b00;
    localparam trit2_t TRIT2_POS  = 2'b01;
    localparam trit2_t TRIT2_NEG  = 2'b11;

    typedef struct packed {
        logic              valid;
        logic signed [4:0] value;
    } tryte_value_t;

    typedef enum logic {
        ST_FILL,
        ST_HOLD
    } loader_state_t;

    // Index 0 ('9') is zero, indices 1..13 ('A'..'M') are positive and the
    // upper half ('N'..'Z') wraps round to -13..-1. Unknown bytes give a
    // zero value with valid cleared.
    function automatic tryte_value_t char_to_tryte_value(input logic [7:0] ch);
        tryte_value_t r;
        r.valid = 1'b0;
        r.value = '0;
        for (int i = 0; i < TRYTE_ALPHABET_SIZE; i++) begin
            if (ch == TRYTE_STRING[8*(TRYTE_ALPHABET_SIZE-1-i) +: 8]) begin
                r.valid = 1'b1;
                r.value = (i <= MAX_TRYTE_VALUE) ? 5'(i) : 5'(i - TRYTE_ALPHABET_SIZE);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tryte_decoder.sv
// ---------------------------------------------------------------------------
// tryte_decoder
// Combinational ASCII tryte character to three balanced trits.
//   ch_i       in   8  ASCII character
//   trits_o    out  6  {t2, t1, t0} as trit2_t, t0 in the low bits
//   invalid_o  out  1  character is not in the tryte alphabet
// ---------------------------------------------------------------------------
module tryte_decoder
    import trinary_pkg::*;
(
    input  logic [7:0] ch_i,
    output logic [5:0] trits_o,
    output logic       invalid_o
);

    // Offsetting the value by +13 (= 1 + 3 + 9) turns balanced ternary into
    // ordinary base-3 digits 0..2, each of which maps to trit (digit - 1).
    function automatic trit2_t digit_to_trit(input logic [4:0] d);
        trit2_t t;
        case (d)
            5'd0:    t = TRIT2_NEG;
            5'd1:    t = TRIT2_ZERO;
            default: t = TRIT2_POS;
        endcase
        return t;
    endfunction

    tryte_value_t tv;
    logic [4:0]   offset_val;
    logic [4:0]   digit0;
    logic [4:0]   digit1;
    logic [4:0]   digit2;

    // Decode the character, then split the offset value into base-3 digits.
    // Invalid characters are forced to three zero trits.
    always_comb begin
        tv         = char_to_tryte_value(ch_i);
        offset_val = $unsigned(tv.value) + 5'(MAX_TRYTE_VALUE);
        digit0     = offset_val % 5'd3;
        digit1     = (offset_val / 5'd3) % 5'd3;
        digit2     = offset_val / 5'd9;
        invalid_o  = ~tv.valid;
        trits_o    = '0;
        if (tv.valid) begin
            trits_o = {digit_to_trit(digit2), digit_to_trit(digit1), digit_to_trit(digit0)};
        end
    end

endmodule

// File: rtl/tryte_to_trit_loader.sv
// ---------------------------------------------------------------------------
// tryte_to_trit_loader
// Streams ASCII trytes in, packs them into blocks of TRYTES_PER_BLOCK trytes
// (3 trits each) and hands each block to the Curl absorb stage.
//   clk, rst_n          clock, asynchronous active-low reset
//   s_valid/s_ready     tryte input handshake, s_data = ASCII character,
//                       s_last = final tryte of the message
//   m_valid/m_ready     block output handshake
//   m_trits             packed trits, trit j at bits [2j+1:2j]
//   m_last              block ends the message
//   m_err               block contains at least one invalid character
// ---------------------------------------------------------------------------
module tryte_to_trit_loader
    import trinary_pkg::*;
#(
    parameter int TRYTES_PER_BLOCK = 81
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [7:0]                    s_data,
    input  logic                          s_last,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [6*TRYTES_PER_BLOCK-1:0] m_trits,
    output logic                          m_last,
    output logic                          m_err
);

    localparam int TRITS_PER_BLOCK = NUMBER_OF_TRITS_IN_A_TRYTE * TRYTES_PER_BLOCK;
    localparam int CNT_W           = $clog2(TRYTES_PER_BLOCK);
    localparam int BUF_W           = 2 * TRITS_PER_BLOCK;
    localparam int TRYTE_W         = 2 * NUMBER_OF_TRITS_IN_A_TRYTE;

    loader_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BUF_W-1:0] buf_q, buf_d;
    logic             last_q, last_d;
    logic             err_q, err_d;

    logic [TRYTE_W-1:0] dec_trits;
    logic               dec_invalid;

    tryte_decoder u_decoder (
        .ch_i      (s_data),
        .trits_o   (dec_trits),
        .invalid_o (dec_invalid)
    );

    // State register. Reset discards any partial block immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FILL;
            cnt_q   <= '0;
            buf_q   <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    // FILL writes each accepted tryte at slot cnt; the block closes on the
    // last slot or on s_last, and cnt is left in place until hand-off so it
    // never wraps. HOLD freezes everything until the Curl stage takes the
    // block, then clears the buffer so unwritten slots of the next block
    // read as zero padding.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        last_d  = last_q;
        err_d   = err_q;
        case (state_q)
            ST_FILL: begin
                if (s_valid) begin
                    for (int k = 0; k < TRYTES_PER_BLOCK; k++) begin
                        if (cnt_q == CNT_W'(k)) begin
                            buf_d[TRYTE_W*k +: TRYTE_W] = dec_trits;
                        end
                    end
                    err_d = err_q | dec_invalid;
                    if (s_last || (cnt_q == CNT_W'(TRYTES_PER_BLOCK - 1))) begin
                        state_d = ST_HOLD;
                        last_d  = s_last;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (m_ready) begin
                    state_d = ST_FILL;
                    cnt_d   = '0;
                    buf_d   = '0;
                    last_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    // Both ready and valid are pure decodes of the registered state, so
    // there is no combinational path from m_ready to s_ready.
    always_comb begin
        s_ready = (state_q == ST_FILL);
        m_valid = (state_q == ST_HOLD);
        m_trits = buf_q;
        m_last  = last_q;
        m_err   = err_q;
    end

endmodule

// File: tb/tb_tryte_to_trit_loader.sv
// ---------------------------------------------------------------------------
// tb_tryte_to_trit_loader
// Self-checking bench: directed messages with literal expectations plus a
// reference model that rebuilds every block from the accepted characters.
// ---------------------------------------------------------------------------
module tb_tryte_to_trit_loader;

    localparam int T    = 81;
    localparam int W    = 6 * T;
    localparam int NMSG = 10;

    typedef struct {
        logic [W-1:0] trits;
        logic         last;
        logic         err;
    } blk_t;

    logic         clk;
    logic         rst_n;
    logic         s_valid;
    logic         s_ready;
    logic [7:0]   s_data;
    logic         s_last;
    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] m_trits;
    logic         m_last;
    logic         m_err;

    int tests;
    int fails;

    logic [7:0] partQ[$];
    blk_t       expQ[$];
    logic         prevHold;
    logic [W-1:0] prevTrits;
    logic         prevLast;
    logic         prevErr;
    bit           randDone;

    tryte_to_trit_loader #(.TRYTES_PER_BLOCK(T)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_trits (m_trits),
        .m_last  (m_last),
        .m_err   (m_err)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: counts it, and reports a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Character value from the alphabet order; 99 marks an invalid byte.
    function automatic int modelValue(input logic [7:0] ch);
        string alpha;
        alpha = "9ABCDEFGHIJKLMNOPQRSTUVWXYZ";
        for (int i = 0; i < 27; i++) begin
            if (alpha[i] == ch) return (i <= 13) ? i : i - 27;
        end
        return 99;
    endfunction

    function automatic logic [1:0] encTrit(input int t);
        if (t > 0) return 2'b01;
        if (t < 0) return 2'b11;
        return 2'b00;
    endfunction

    // Builds the expected block from the message characters by plain
    // balanced-ternary arithmetic, leaving unused positions zero.
    function automatic blk_t buildBlock(input logic [7:0] chars[$], input logic isLast);
        blk_t b;
        int v;
        int r;
        b.trits = '0;
        b.last  = isLast;
        b.err   = 1'b0;
        for (int k = 0; k < chars.size(); k++) begin
            v = modelValue(chars[k]);
            if (v == 99) begin
                b.err = 1'b1;
                v = 0;
            end
            for (int j = 0; j < 3; j++) begin
                r = v % 3;
                if (r == 2)  r = -1;
                if (r == -2) r = 1;
                b.trits[2*(3*k+j) +: 2] = encTrit(r);
                v = (v - r) / 3;
            end
        end
        return b;
    endfunction

    // Compare process, sampled on the falling edge: tracks accepted trytes,
    // checks each handed-off block against the model and checks that a
    // stalled block stays put.
    always @(negedge clk) begin
        if (!rst_n) begin
            partQ.delete();
            expQ.delete();
            prevHold = 1'b0;
        end else begin
            if (prevHold) begin
                checkOutput("hold m_valid", W'(m_valid), W'(1));
                checkOutput("hold m_trits", m_trits, prevTrits);
                checkOutput("hold m_last", W'(m_last), W'(prevLast));
                checkOutput("hold m_err", W'(m_err), W'(prevErr));
            end
            if (m_valid && m_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected block", W'(1), W'(0));
                end else begin
                    checkOutput("model m_trits", m_trits, expQ[0].trits);
                    checkOutput("model m_last", W'(m_last), W'(expQ[0].last));
                    checkOutput("model m_err", W'(m_err), W'(expQ[0].err));
                    void'(expQ.pop_front());
                end
            end
            if (s_valid && s_ready) begin
                partQ.push_back(s_data);
                if (s_last || partQ.size() == T) begin
                    expQ.push_back(buildBlock(partQ, s_last));
                    partQ.delete();
                end
            end
            prevHold  = m_valid && !m_ready;
            prevTrits = m_trits;
            prevLast  = m_last;
            prevErr   = m_err;
        end
    end

    // Presents one tryte (called just after a rising edge) and returns just
    // after the edge that accepted it.
    task automatic applyStimulus(input logic [7:0] ch, input logic isLast);
        bit acc;
        s_valid = 1'b1;
        s_data  = ch;
        s_last  = isLast;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                s_valid = 1'b0;
                s_last  = 1'b0;
                return;
            end
        end
        $display("[TB] FAIL send timeout: got no s_ready, expected s_ready=1");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "[TB] stalled");
    endtask

    task automatic waitBlock(input string name);
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (m_valid) return;
        end
        checkOutput(name, W'(0), W'(1));
    endtask

    task automatic releaseBlock();
        @(posedge clk);
        #1 m_ready = 1'b1;
        @(posedge clk);
        #1 m_ready = 1'b0;
    endtask

    initial begin
        string msg;
        string alpha;
        int len;
        tests    = 0;
        fails    = 0;
        prevHold = 1'b0;
        randDone = 1'b0;
        alpha    = "9ABCDEFGHIJKLMNOPQRSTUVWXYZ";
        rst_n    = 1'b0;
        s_valid  = 1'b0;
        s_data   = 8'h00;
        s_last   = 1'b0;
        m_ready  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        checkOutput("reset s_ready", W'(s_ready), W'(1));
        checkOutput("reset m_valid", W'(m_valid), W'(0));
        checkOutput("reset m_trits", m_trits, W'(0));
        checkOutput("reset m_last", W'(m_last), W'(0));
        checkOutput("reset m_err", W'(m_err), W'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 81 x 'A' ending the message
        for (int i = 0; i < T; i++) applyStimulus("A", i == T - 1);
        checkOutput("A latency m_valid", W'(m_valid), W'(1));
        checkOutput("A latency s_ready", W'(s_ready), W'(0));
        waitBlock("A block timeout");
        checkOutput("A m_trits", m_trits, {T{6'b000001}});
        checkOutput("A m_last", W'(m_last), W'(1));
        checkOutput("A m_err", W'(m_err), W'(0));
        releaseBlock();
        checkOutput("A after handoff m_valid", W'(m_valid), W'(0));
        checkOutput("A after handoff s_ready", W'(s_ready), W'(1));

        // Short message "NZM9", zero padded
        msg = "NZM9";
        for (int i = 0; i < 4; i++) applyStimulus(msg[i], i == 3);
        waitBlock("NZM9 block timeout");
        checkOutput("NZM9 m_trits", m_trits,
                    {{(W-24){1'b0}}, 6'b000000, 6'b010101, 6'b000011, 6'b111111});
        checkOutput("NZM9 m_last", W'(m_last), W'(1));
        releaseBlock();

        // 162 x 'Z', first block stalled for several cycles
        for (int i = 0; i < T; i++) applyStimulus("Z", 1'b0);
        waitBlock("Z1 block timeout");
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            checkOutput("Z1 stall s_ready", W'(s_ready), W'(0));
            checkOutput("Z1 stall m_trits", m_trits, {T{6'b000011}});
        end
        checkOutput("Z1 m_last", W'(m_last), W'(0));
        releaseBlock();
        for (int i = 0; i < T; i++) applyStimulus("Z", i == T - 1);
        waitBlock("Z2 block timeout");
        checkOutput("Z2 m_trits", m_trits, {T{6'b000011}});
        checkOutput("Z2 m_last", W'(m_last), W'(1));
        releaseBlock();

        // Invalid 'a' at index 10, then a clean follow-up block
        for (int i = 0; i < T; i++) applyStimulus((i == 10) ? 8'h61 : 8'h41, 1'b0);
        waitBlock("err block timeout");
        checkOutput("err m_trits", m_trits, {{70{6'b000001}}, 6'b000000, {10{6'b000001}}});
        checkOutput("err m_err", W'(m_err), W'(1));
        checkOutput("err m_last", W'(m_last), W'(0));
        releaseBlock();
        applyStimulus("A", 1'b0);
        applyStimulus("B", 1'b1);
        waitBlock("clean block timeout");
        checkOutput("clean m_trits", m_trits, {{(W-12){1'b0}}, 6'b000111, 6'b000001});
        checkOutput("clean m_err", W'(m_err), W'(0));
        releaseBlock();

        // Invalid character together with s_last
        applyStimulus("#", 1'b1);
        waitBlock("errlast block timeout");
        checkOutput("errlast m_err", W'(m_err), W'(1));
        checkOutput("errlast m_last", W'(m_last), W'(1));
        releaseBlock();

        // Reset in the middle of a block
        for (int i = 0; i < 40; i++) applyStimulus("C", 1'b0);
        rst_n = 1'b0;
        #2;
        checkOutput("midreset m_valid", W'(m_valid), W'(0));
        checkOutput("midreset m_trits", m_trits, W'(0));
        checkOutput("midreset s_ready", W'(s_ready), W'(1));
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            checkOutput("postreset m_valid", W'(m_valid), W'(0));
        end
        for (int i = 0; i < T; i++) applyStimulus("B", i == T - 1);
        waitBlock("B block timeout");
        checkOutput("B m_trits", m_trits, {T{6'b000111}});
        checkOutput("B m_last", W'(m_last), W'(1));
        checkOutput("B m_err", W'(m_err), W'(0));
        releaseBlock();

        // Random throttling on both sides over several messages
        fork
            begin
                for (int m = 0; m < NMSG; m++) begin
                    len = $urandom_range(1, 300);
                    for (int i = 0; i < len; i++) begin
                        int idx;
                        idx = $urandom_range(0, 29);
                        repeat ($urandom_range(0, 2)) begin
                            @(posedge clk);
                            #1;
                        end
                        applyStimulus((idx < 27) ? alpha[idx] : 8'h7A, i == len - 1);
                    end
                end
                for (int n = 0; n < 2000 && (expQ.size() != 0 || m_valid); n++) begin
                    @(posedge clk);
                    #1;
                end
                randDone = 1'b1;
            end
            begin
                while (!randDone) begin
                    @(posedge clk);
                    #1 m_ready = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
                end
                m_ready = 1'b0;
            end
        join
        checkOutput("random pending blocks", W'(expQ.size()), W'(0));
        checkOutput("random partial trytes", W'(partQ.size()), W'(0));
        checkOutput("random final m_valid", W'(m_valid), W'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
